lfsr: RTL and testbench

LFSR -- requirements
Module: lfsr

---
 rtl/lfsr.sv | 126 ++++++++++++
 tb/tb_lfsr.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr -- Fibonacci linear feedback shift register, left-shifting.
//
// The register 'shift' moves left by one bit on every clock edge. The new
// LSB is the XOR of the maximal-length tap bits for WIDTH; the taps come from
// the XAPP052 table for widths 3..32. Any nonzero seed gives a sequence with
// period 2^WIDTH-1.
//
// 'q' is the MSB of the register and 'state' is the whole register. Both are
// taken straight from the flops, so they add no latency. 'wrap' is a
// registered pulse. It is high in the cycle where a shift (not a reset load)
// has brought the register back to SEED.
//
// Optional feature, controlled by the macro LFSR_LOCKUP_RECOVERY_EN:
//   When the macro is defined, an all-zero register is reloaded with 1
//   instead of shifting. This lets SEED=0 start running.
//   When the macro is not defined, no recovery logic is built, and an
//   all-zero register stays locked at zero.
// ---------------------------------------------------------------------------
module lfsr #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'b0001)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             q,
    output logic [WIDTH-1:0] state,
    output logic             wrap
);

    // Tap mask for each supported width. Bit n is set when register bit n
    // (0-based) feeds the XOR. The masks are the XAPP052 taps with 1 subtracted.
    function automatic logic [31:0] tap_mask(input int w);
        logic [31:0] m;
        m = 32'h0;
        case (w)
            3:  m = (32'h1 << 2)  | (32'h1 << 1);
            4:  m = (32'h1 << 3)  | (32'h1 << 2);
            5:  m = (32'h1 << 4)  | (32'h1 << 2);
            6:  m = (32'h1 << 5)  | (32'h1 << 4);
            7:  m = (32'h1 << 6)  | (32'h1 << 5);
            8:  m = (32'h1 << 7)  | (32'h1 << 5)  | (32'h1 << 4)  | (32'h1 << 3);
            9:  m = (32'h1 << 8)  | (32'h1 << 4);
            10: m = (32'h1 << 9)  | (32'h1 << 6);
            11: m = (32'h1 << 10) | (32'h1 << 8);
            12: m = (32'h1 << 11) | (32'h1 << 5)  | (32'h1 << 3)  | (32'h1 << 0);
            13: m = (32'h1 << 12) | (32'h1 << 3)  | (32'h1 << 2)  | (32'h1 << 0);
            14: m = (32'h1 << 13) | (32'h1 << 4)  | (32'h1 << 2)  | (32'h1 << 0);
            15: m = (32'h1 << 14) | (32'h1 << 13);
            16: m = (32'h1 << 15) | (32'h1 << 14) | (32'h1 << 12) | (32'h1 << 3);
            17: m = (32'h1 << 16) | (32'h1 << 13);
            18: m = (32'h1 << 17) | (32'h1 << 10);
            19: m = (32'h1 << 18) | (32'h1 << 5)  | (32'h1 << 1)  | (32'h1 << 0);
            20: m = (32'h1 << 19) | (32'h1 << 16);
            21: m = (32'h1 << 20) | (32'h1 << 18);
            22: m = (32'h1 << 21) | (32'h1 << 20);
            23: m = (32'h1 << 22) | (32'h1 << 17);
            24: m = (32'h1 << 23) | (32'h1 << 22) | (32'h1 << 21) | (32'h1 << 16);
            25: m = (32'h1 << 24) | (32'h1 << 21);
            26: m = (32'h1 << 25) | (32'h1 << 5)  | (32'h1 << 1)  | (32'h1 << 0);
            27: m = (32'h1 << 26) | (32'h1 << 4)  | (32'h1 << 1)  | (32'h1 << 0);
            28: m = (32'h1 << 27) | (32'h1 << 24);
            29: m = (32'h1 << 28) | (32'h1 << 26);
            30: m = (32'h1 << 29) | (32'h1 << 5)  | (32'h1 << 3)  | (32'h1 << 0);
            31: m = (32'h1 << 30) | (32'h1 << 27);
            32: m = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1)  | (32'h1 << 0);
            default: m = 32'h0;
        endcase
        return m;
    endfunction

    localparam logic [31:0] TAPS = tap_mask(WIDTH);

    // Stop elaboration if WIDTH has no entry in the tap table.
    generate
        if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "lfsr: WIDTH=%0d is outside the supported range 3..32", WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] shift;
    logic             fb;
    logic [WIDTH-1:0] shifted;

    assign fb      = ^(shift & TAPS[WIDTH-1:0]);
    assign shifted = {shift[WIDTH-2:0], fb};

    assign q     = shift[WIDTH-1];
    assign state = shift;

`ifdef LFSR_LOCKUP_RECOVERY_EN
    localparam logic [WIDTH-1:0] RESTART = {{(WIDTH-1){1'b0}}, 1'b1};

    logic lockup;
    assign lockup = (shift == '0);

    // Register update. Reset loads SEED. An all-zero register restarts at 1.
    // Otherwise the register shifts, and wrap flags a return to SEED.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift <= SEED;
            wrap  <= 1'b0;
        end else if (lockup) begin
            shift <= RESTART;
            wrap  <= 1'b0;
        end else begin
            shift <= shifted;
            wrap  <= (shifted == SEED);
        end
    end
`else
    // Register update. Reset loads SEED. Otherwise the register shifts, and
    // wrap flags a return to SEED. With SEED=0 the register is stuck at zero,
    // so wrap stays high on every non-reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift <= SEED;
            wrap  <= 1'b0;
        end else begin
            shift <= shifted;
            wrap  <= (shifted == SEED);
        end
    end
`endif

endmodule

// File: tb/tb_lfsr.sv
// ---------------------------------------------------------------------------
// tb_lfsr -- directed, self-checking bench for lfsr.
//
// The bench has three instances:
//   uut  : defaults, WIDTH=4 and SEED=0001
//   uut8 : WIDTH=8 and SEED=8'h01
//   uut0 : WIDTH=4 and SEED=0
// Each instance has its own reset, so the instances can be exercised one
// after another.
// ---------------------------------------------------------------------------
module tb_lfsr;

    logic       clk;
    logic       rst;
    logic       rst8;
    logic       rst0;

    logic       q;
    logic [3:0] state;
    logic       wrap;
    logic       q8;
    logic [7:0] state8;
    logic       wrap8;
    logic       q0;
    logic [3:0] state0;
    logic       wrap0;

    int checks   = 0;
    int failures = 0;

    lfsr uut (
        .clk   (clk),
        .reset (rst),
        .q     (q),
        .state (state),
        .wrap  (wrap)
    );

    lfsr #(.WIDTH(8), .SEED(8'h01)) uut8 (
        .clk   (clk),
        .reset (rst8),
        .q     (q8),
        .state (state8),
        .wrap  (wrap8)
    );

    lfsr #(.WIDTH(4), .SEED(4'b0000)) uut0 (
        .clk   (clk),
        .reset (rst0),
        .q     (q0),
        .state (state0),
        .wrap  (wrap0)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed 4-bit sequence for taps 3,2, starting after 0001.
    logic [3:0] seq4 [15] = '{4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                              4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                              4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0001};

    // Drive the three resets, then wait for one rising edge and settle 1 unit.
    task automatic applyStimulus(input logic r, input logic r8, input logic r0);
        rst  = r;
        rst8 = r8;
        rst0 = r0;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [255:0] seen;
    int           dup8;
    int           zero8;
    int           wraps8;
    int           wrap_edge8;
    logic [3:0]   cur;

    initial begin
        rst  = 1'b1;
        rst8 = 1'b1;
        rst0 = 1'b1;

        // Reset for one edge: shift=0001, q=0, wrap=0.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_shift", 32'(uut.shift), 32'h1);
        checkOutput("reset_state", 32'(state), 32'h1);
        checkOutput("reset_q", 32'(q), 32'h0);
        checkOutput("reset_wrap", 32'(wrap), 32'h0);
        checkOutput("reset8_state", 32'(state8), 32'h01);
        checkOutput("reset0_state", 32'(state0), 32'h0);

        // Reset held for a second edge: shift must stay at SEED.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_hold_shift", 32'(uut.shift), 32'h1);

        // Release reset and take two steps: 0010, then 0100.
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("step1_shift", 32'(uut.shift), 32'h2);
        checkOutput("step1_q", 32'(q), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("step2_shift", 32'(uut.shift), 32'h4);
        checkOutput("step2_q", 32'(q), 32'h0);

        // Full period from 0001. wrap may pulse only on the 15th edge.
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("period_start", 32'(uut.shift), 32'h1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            cur = seq4[i];
            checkOutput($sformatf("period_shift[%0d]", i + 1), 32'(state), 32'(cur));
            checkOutput($sformatf("period_q[%0d]", i + 1), 32'(q), 32'(cur[3]));
            checkOutput($sformatf("period_wrap[%0d]", i + 1), 32'(wrap),
                        (i == 14) ? 32'h1 : 32'h0);
        end

        // Reset in the middle of the sequence: it reloads 0001 and then restarts.
        applyStimulus(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("mid_before", 32'(uut.shift), 32'h6);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("mid_reset_shift", 32'(uut.shift), 32'h1);
        checkOutput("mid_reset_wrap", 32'(wrap), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("mid_restart", 32'(uut.shift), 32'h2);
        checkOutput("mid_restart_wrap", 32'(wrap), 32'h0);

        // WIDTH=8: run 255 edges. All states must be distinct and nonzero,
        // and wrap must pulse once, on edge 255.
        seen       = '0;
        dup8       = 0;
        zero8      = 0;
        wraps8     = 0;
        wrap_edge8 = 0;
        for (int e = 1; e <= 255; e++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            if (e == 4) checkOutput("w8_edge4", 32'(state8), 32'h11);
            if (state8 == 8'h00) zero8++;
            if (seen[state8]) dup8++;
            seen[state8] = 1'b1;
            if (wrap8) begin
                wraps8++;
                wrap_edge8 = e;
            end
        end
        checkOutput("w8_duplicates", 32'(dup8), 32'h0);
        checkOutput("w8_zero_states", 32'(zero8), 32'h0);
        checkOutput("w8_wrap_count", 32'(wraps8), 32'h1);
        checkOutput("w8_wrap_edge", 32'(wrap_edge8), 32'd255);
        checkOutput("w8_final_state", 32'(uut8.shift), 32'h01);

        // SEED=0: with recovery the register restarts at 0001 and follows the
        // normal sequence. Without recovery it stays locked at zero.
`ifdef LFSR_LOCKUP_RECOVERY_EN
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("seed0_recover", 32'(uut0.shift), 32'h1);
        checkOutput("seed0_recover_wrap", 32'(wrap0), 32'h0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            cur = seq4[i];
            checkOutput($sformatf("seed0_seq[%0d]", i + 1), 32'(state0), 32'(cur));
        end
`else
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("seed0_lock_shift[%0d]", i + 1), 32'(uut0.shift), 32'h0);
            checkOutput($sformatf("seed0_lock_q[%0d]", i + 1), 32'(q0), 32'h0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
